pong_referee: RTL and testbench

//  Game-flow controller that drives the score-event side of the scoreboard/display block.

---
 rtl/pong_referee.sv | 100 ++++++++++
 tb/tb_pong_referee.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/pong_referee.sv
// Pong game-flow referee: sequences serve/play/pause/game-over, issues frame-aligned
// point strobes and score_reset to the scoreboard, and consumes its win flag.
module pong_referee #(
  parameter int XW          = 10,
  parameter int LEFT_EDGE   = 8,
  parameter int RIGHT_EDGE  = 631,
  parameter int HOLD_FRAMES = 60
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          frame,
  input  logic [XW-1:0] ball_x,
  input  logic          serve,
  input  logic          win,
  output logic          right_en,
  output logic          left_en,
  output logic          score_reset,
  output logic          ball_hold,
  output logic          serve_left,
  output logic          game_over
);

  localparam int CW = $clog2(HOLD_FRAMES + 1);
  localparam logic [XW-1:0] LEFT_X   = XW'(LEFT_EDGE);
  localparam logic [XW-1:0] RIGHT_X  = XW'(RIGHT_EDGE);
  localparam logic [CW-1:0] HOLD_END = CW'(HOLD_FRAMES - 1);

  typedef enum logic [2:0] {
    RESET_SCORE,
    SERVE,
    PLAY,
    HOLD,
    OVER
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] hold_cnt, hold_cnt_d;
  logic          serve_q;
  logic          serve_left_d;
  logic          serve_edge;
  logic          in_play_frame;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RESET_SCORE;
      hold_cnt   <= '0;
      serve_q    <= 1'b0;
      serve_left <= 1'b0;
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      serve_q    <= serve;
      serve_left <= serve_left_d;
    end
  end

  always_comb begin
    state_d       = state;
    hold_cnt_d    = hold_cnt;
    serve_left_d  = serve_left;
    serve_edge    = serve & ~serve_q;
    in_play_frame = (state == PLAY) & frame;
    // Right-player point (ball out on the left) wins any tie between the two edges.
    right_en      = in_play_frame & (ball_x <= LEFT_X);
    left_en       = in_play_frame & (ball_x >= RIGHT_X) & ~right_en;
    score_reset   = (state == RESET_SCORE);
    ball_hold     = (state != PLAY);
    game_over     = (state == OVER);

    unique case (state)
      RESET_SCORE: if (frame) state_d = SERVE;
      SERVE:       if (serve_edge) state_d = PLAY;
      PLAY: begin
        if (right_en | left_en) begin
          serve_left_d = right_en;
          if (win) begin
            state_d = OVER;
          end else begin
            state_d    = HOLD;
            hold_cnt_d = '0;
          end
        end
      end
      HOLD: begin
        if (frame) begin
          if (hold_cnt == HOLD_END) state_d = SERVE;
          if (hold_cnt != '1) hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      OVER: begin
        if (serve_edge) begin
          state_d      = RESET_SCORE;
          serve_left_d = 1'b0;
        end
      end
      default: state_d = RESET_SCORE;
    endcase
  end

endmodule

// File: tb/tb_pong_referee.sv
// Directed, table-driven check of pong_referee with HOLD_FRAMES=3, plus hand sequences
// for reset during a live strobe and the coincident-edge configuration.
module tb_pong_referee;

  logic       clk = 1'b0;
  logic       reset, frame, serve, win;
  logic [9:0] ball_x;
  logic       right_en, left_en, score_reset, ball_hold, serve_left, game_over;

  logic       frame2, serve2;
  logic [9:0] ball_x2;
  logic       right_en2, left_en2, score_reset2, ball_hold2, serve_left2, game_over2;

  int unsigned errors = 0;
  int unsigned checks = 0;

  always #5 clk = ~clk;

  pong_referee #(.XW(10), .LEFT_EDGE(8), .RIGHT_EDGE(631), .HOLD_FRAMES(3)) dut (
    .clk(clk), .reset(reset), .frame(frame), .ball_x(ball_x), .serve(serve), .win(win),
    .right_en(right_en), .left_en(left_en), .score_reset(score_reset),
    .ball_hold(ball_hold), .serve_left(serve_left), .game_over(game_over)
  );

  pong_referee #(.XW(10), .LEFT_EDGE(8), .RIGHT_EDGE(8), .HOLD_FRAMES(3)) dut_eq (
    .clk(clk), .reset(reset), .frame(frame2), .ball_x(ball_x2), .serve(serve2), .win(1'b0),
    .right_en(right_en2), .left_en(left_en2), .score_reset(score_reset2),
    .ball_hold(ball_hold2), .serve_left(serve_left2), .game_over(game_over2)
  );

  typedef struct {
    logic       rst;
    logic       fr;
    logic [9:0] x;
    logic       srv;
    logic       w;
    logic [5:0] exp;  // {right_en, left_en, score_reset, ball_hold, serve_left, game_over}
  } vec_t;

  vec_t vecs[36];

  task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got {R,L,SR,BH,SL,GO}=%b, expected %b", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic rst, input logic fr, input int x, input logic srv,
                              input logic w, input logic [5:0] exp);
    vec_t v;
    v.rst = rst; v.fr = fr; v.x = 10'(x); v.srv = srv; v.w = w; v.exp = exp;
    return v;
  endfunction

  initial begin
    //            rst fr  x    srv w   R L SR BH SL GO
    vecs[0]  = mk(1, 0, 300, 0, 0, 6'b00_11_00);  // reset state
    vecs[1]  = mk(0, 0, 300, 0, 0, 6'b00_11_00);  // RESET_SCORE waits for frame
    vecs[2]  = mk(0, 1, 300, 0, 0, 6'b00_11_00);  // frame -> SERVE
    vecs[3]  = mk(0, 0, 300, 0, 0, 6'b00_01_00);
    vecs[4]  = mk(0, 0, 300, 1, 0, 6'b00_01_00);  // serve edge -> PLAY
    vecs[5]  = mk(0, 0, 5,   1, 0, 6'b00_00_00);  // out of field, no frame: ignored
    vecs[6]  = mk(0, 1, 5,   0, 0, 6'b10_00_00);  // right point -> HOLD
    vecs[7]  = mk(0, 0, 300, 1, 0, 6'b00_01_10);  // edge in HOLD dropped
    vecs[8]  = mk(0, 1, 300, 0, 0, 6'b00_01_10);  // hold frame 1
    vecs[9]  = mk(0, 1, 300, 1, 0, 6'b00_01_10);  // hold frame 2
    vecs[10] = mk(0, 0, 300, 1, 0, 6'b00_01_10);  // still HOLD after 2nd
    vecs[11] = mk(0, 1, 300, 1, 0, 6'b00_01_10);  // hold frame 3 -> SERVE
    vecs[12] = mk(0, 0, 300, 1, 0, 6'b00_01_10);  // held serve: no edge
    vecs[13] = mk(0, 1, 5,   1, 0, 6'b00_01_10);  // frame in SERVE: no strobe
    vecs[14] = mk(0, 0, 300, 0, 0, 6'b00_01_10);
    vecs[15] = mk(0, 0, 300, 1, 0, 6'b00_01_10);  // re-press -> PLAY
    vecs[16] = mk(0, 1, 300, 1, 0, 6'b00_00_10);  // in field
    vecs[17] = mk(0, 1, 640, 0, 1, 6'b01_00_10);  // left point with win -> OVER
    vecs[18] = mk(0, 0, 640, 0, 0, 6'b00_01_01);
    vecs[19] = mk(0, 0, 300, 1, 0, 6'b00_01_01);  // edge -> RESET_SCORE
    vecs[20] = mk(0, 0, 300, 1, 0, 6'b00_11_00);
    vecs[21] = mk(0, 1, 300, 0, 0, 6'b00_11_00);
    vecs[22] = mk(0, 0, 300, 1, 0, 6'b00_01_00);
    vecs[23] = mk(0, 1, 5,   0, 1, 6'b10_00_00);  // right point with win
    vecs[24] = mk(0, 0, 300, 0, 0, 6'b00_01_11);
    vecs[25] = mk(0, 0, 300, 1, 0, 6'b00_01_11);  // OVER clears serve_left
    vecs[26] = mk(0, 0, 300, 0, 0, 6'b00_11_00);
    vecs[27] = mk(0, 1, 300, 0, 0, 6'b00_11_00);
    vecs[28] = mk(0, 0, 300, 1, 0, 6'b00_01_00);
    vecs[29] = mk(0, 1, 631, 0, 0, 6'b01_00_00);  // exact right edge
    vecs[30] = mk(0, 1, 300, 0, 0, 6'b00_01_00);  // hold frame 1
    vecs[31] = mk(1, 0, 300, 0, 0, 6'b00_11_00);  // reset mid-HOLD
    vecs[32] = mk(0, 1, 300, 0, 0, 6'b00_11_00);
    vecs[33] = mk(0, 0, 300, 1, 0, 6'b00_01_00);
    vecs[34] = mk(0, 1, 9,   0, 0, 6'b00_00_00);  // just inside left edge
    vecs[35] = mk(0, 1, 630, 0, 0, 6'b00_00_00);  // just inside right edge

    reset = 1'b1; frame = 1'b0; ball_x = 10'd300; serve = 1'b0; win = 1'b0;
    frame2 = 1'b0; ball_x2 = 10'd300; serve2 = 1'b0;

    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      reset = vecs[i].rst; frame = vecs[i].fr; ball_x = vecs[i].x;
      serve = vecs[i].srv; win = vecs[i].w;
      #1;
      check($sformatf("vec%0d", i),
            {right_en, left_en, score_reset, ball_hold, serve_left, game_over}, vecs[i].exp);
    end

    // Reset asserted while a right strobe is live: strobe must drop immediately.
    @(negedge clk);
    frame = 1'b1; ball_x = 10'd8; serve = 1'b0; win = 1'b0;
    #1;
    check("edge8_strobe", {right_en, left_en, score_reset, ball_hold, serve_left, game_over},
          6'b10_00_00);
    #2 reset = 1'b1;
    #1;
    check("reset_in_strobe", {right_en, left_en, score_reset, ball_hold, serve_left, game_over},
          6'b00_11_00);

    // Coincident edges: ball_x on both boundaries scores only for the right player.
    @(negedge clk);
    reset = 1'b0; frame = 1'b0;
    frame2 = 1'b1;
    @(negedge clk);
    frame2 = 1'b0; serve2 = 1'b1;
    #1;
    check("eq_serve", {right_en2, left_en2, score_reset2, ball_hold2, serve_left2, game_over2},
          6'b00_01_00);
    @(negedge clk);
    serve2 = 1'b0; frame2 = 1'b1; ball_x2 = 10'd8;
    #1;
    check("eq_tie", {right_en2, left_en2, score_reset2, ball_hold2, serve_left2, game_over2},
          6'b10_00_00);
    @(negedge clk);
    frame2 = 1'b0;
    #1;
    check("eq_hold", {right_en2, left_en2, score_reset2, ball_hold2, serve_left2, game_over2},
          6'b00_01_10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
